// File: rtl/wb_fake_slave.sv
// wb_fake_slave - Wishbone slave model that terminates a fake_master bus.
//
// Takes one request at a time, backs it with a small byte-selectable
// memory and answers every accepted request with exactly one ACK, RTY
// or ERR pulse ACK_LATENCY cycles after acceptance.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   CYC_I, STB_I      bus cycle / strobe
//   WE_I              1 = write
//   DAT_I, SEL_I      write data, byte enables
//   ADR_I             byte address
//   CTI_I             cycle type, ignored (every beat is independent)
//   DAT_O             read data, nonzero only alongside a read ACK
//   ACK_O/RTY_O/ERR_O termination pulses (registered)
//   STALL_O           request not accepted this cycle (registered)
//
// Build option: FAKE_SLAVE_PIPELINED_EN
//   defined   - pipelined Wishbone, STALL_O high while a request is open
//   undefined - classic Wishbone, STALL_O tied low
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no request open, accepts CYC_I & STB_I
// WAIT  | latency counter running down
// RESP  | termination decided; pulse registered on the exiting edge

`timescale 1ns/1ps

`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_SEL_WIDTH
`define BUS_SEL_WIDTH 4
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 32
`endif

module wb_fake_slave #(
   parameter int ACK_LATENCY   = 3,
   parameter int MEM_ADDR_BITS = 4,
   parameter int ADDR_LSB      = 2,
   parameter int RETRY_PERIOD  = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          CYC_I,
   input  logic                          STB_I,
   input  logic                          WE_I,
   input  logic [`BUS_DATA_WIDTH-1:0]    DAT_I,
   input  logic [`BUS_SEL_WIDTH-1:0]     SEL_I,
   input  logic [`BUS_ADDRESS_WIDTH-1:0] ADR_I,
   input  logic [2:0]                    CTI_I,
   output logic [`BUS_DATA_WIDTH-1:0]    DAT_O,
   output logic                          ACK_O,
   output logic                          RTY_O,
   output logic                          ERR_O,
   output logic                          STALL_O
);

   localparam int DW    = `BUS_DATA_WIDTH;
   localparam int SW    = `BUS_SEL_WIDTH;
   localparam int AW    = `BUS_ADDRESS_WIDTH;
   localparam int DEPTH = 2 ** MEM_ADDR_BITS;

   // The counter is checked for zero before it is decremented, so loading
   // L-2 yields L-2+1 WAIT cycles plus one RESP cycle after acceptance.
   localparam logic [3:0]  LAT_LOAD = (ACK_LATENCY >= 2) ? 4'(ACK_LATENCY - 2) : 4'd0;
   // Divisor kept nonzero so the modulo is well defined when retry is off.
   localparam logic [15:0] RP_DIV   = 16'((RETRY_PERIOD == 0) ? 1 : RETRY_PERIOD);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                     r_state;
   state_t                     w_next;
   logic [3:0]                 r_lat_cnt;
   logic [15:0]                r_req_cnt;
   logic                       r_we;
   logic [AW-1:0]              r_adr;
   logic [SW-1:0]              r_sel;
   logic [DW-1:0]              r_dat;
   logic [DW-1:0]              r_mem [DEPTH];

   logic                       w_accept;
   logic                       w_out_of_range;
   logic                       w_retry;
   logic [MEM_ADDR_BITS-1:0]   w_idx;
   logic                       w_ack;
   logic                       w_rty;
   logic                       w_err;
   logic                       w_stall_nxt;
   logic [DW-1:0]              w_rdata_nxt;
   logic                       w_unused;

   assign w_unused       = ^CTI_I;
   assign w_accept       = (r_state == S_IDLE) && CYC_I && STB_I && !STALL_O;
   assign w_idx          = r_adr[ADDR_LSB +: MEM_ADDR_BITS];
   assign w_out_of_range = (r_adr >> (ADDR_LSB + MEM_ADDR_BITS)) != '0;
   assign w_retry        = (RETRY_PERIOD != 0) && ((r_req_cnt % RP_DIV) == 16'd0);

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = (ACK_LATENCY == 1) ? S_RESP : S_WAIT;
         S_WAIT: begin
            if (!CYC_I)                 w_next = S_IDLE;
            else if (r_lat_cnt == 4'd0) w_next = S_RESP;
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // outputs, computed one cycle ahead and registered below
   always_comb begin
      w_ack = 1'b0;
      w_rty = 1'b0;
      w_err = 1'b0;
      // A dropped CYC_I in RESP abandons the request without any pulse.
      if (r_state == S_RESP && CYC_I) begin
         if (w_out_of_range) w_err = 1'b1;
         else if (w_retry)   w_rty = 1'b1;
         else                w_ack = 1'b1;
      end
      w_rdata_nxt = (w_ack && !r_we) ? r_mem[w_idx] : '0;
`ifdef FAKE_SLAVE_PIPELINED_EN
      w_stall_nxt = (w_next != S_IDLE);
`else
      w_stall_nxt = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lat_cnt <= 4'd0;
         r_req_cnt <= 16'd0;
         r_we      <= 1'b0;
         r_adr     <= '0;
         r_sel     <= '0;
         r_dat     <= '0;
         ACK_O     <= 1'b0;
         RTY_O     <= 1'b0;
         ERR_O     <= 1'b0;
         STALL_O   <= 1'b0;
         DAT_O     <= '0;
      end else begin
         if (w_accept) begin
            r_we      <= WE_I;
            r_adr     <= ADR_I;
            r_sel     <= SEL_I;
            r_dat     <= DAT_I;
            r_req_cnt <= r_req_cnt + 16'd1;
            r_lat_cnt <= LAT_LOAD;
         end else if (r_state == S_WAIT && r_lat_cnt != 4'd0) begin
            r_lat_cnt <= r_lat_cnt - 4'd1;
         end
         ACK_O   <= w_ack;
         RTY_O   <= w_rty;
         ERR_O   <= w_err;
         STALL_O <= w_stall_nxt;
         DAT_O   <= w_rdata_nxt;
      end
   end

   // Memory has no reset; writes land only on the edge that raises ACK_O.
   always_ff @(posedge clk) begin
      if (w_ack && r_we) begin
         for (int i = 0; i < SW; i++) begin
            if (r_sel[i]) r_mem[w_idx][8*i +: 8] <= r_dat[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_wb_fake_slave.sv
`timescale 1ns/1ps

module tb_wb_fake_slave;

   localparam int LAT  = 3;
   localparam int NDUT = 2;
   localparam int RP1  = 3;
`ifdef FAKE_SLAVE_PIPELINED_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc, stb, we;
   logic [31:0] dat_i, adr;
   logic [3:0]  sel;
   logic [2:0]  cti;

   logic [31:0] dat_o   [NDUT];
   logic        ack_o   [NDUT];
   logic        rty_o   [NDUT];
   logic        err_o   [NDUT];
   logic        stall_o [NDUT];

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: one memory image and request count per instance
   logic [31:0] m_mem [NDUT][16];
   int          m_cnt [NDUT];
   int          m_rp  [NDUT];

   always #5 clk = ~clk;

   wb_fake_slave #(.ACK_LATENCY(LAT), .MEM_ADDR_BITS(4), .ADDR_LSB(2), .RETRY_PERIOD(0)) u_dut0 (
      .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .DAT_I(dat_i),
      .SEL_I(sel), .ADR_I(adr), .CTI_I(cti), .DAT_O(dat_o[0]), .ACK_O(ack_o[0]),
      .RTY_O(rty_o[0]), .ERR_O(err_o[0]), .STALL_O(stall_o[0]));

   wb_fake_slave #(.ACK_LATENCY(LAT), .MEM_ADDR_BITS(4), .ADDR_LSB(2), .RETRY_PERIOD(RP1)) u_dut1 (
      .clk(clk), .rst(rst), .CYC_I(cyc), .STB_I(stb), .WE_I(we), .DAT_I(dat_i),
      .SEL_I(sel), .ADR_I(adr), .CTI_I(cti), .DAT_O(dat_o[1]), .ACK_O(ack_o[1]),
      .RTY_O(rty_o[1]), .ERR_O(err_o[1]), .STALL_O(stall_o[1]));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // flags = {ACK, RTY, ERR, STALL}
   task automatic check_dut(input int d, input string tag, input logic [3:0] flags, input logic [31:0] dat);
      check_val($sformatf("%s.d%0d.flags", tag, d),
                {28'd0, ack_o[d], rty_o[d], err_o[d], stall_o[d]}, {28'd0, flags});
      check_val($sformatf("%s.d%0d.dat", tag, d), dat_o[d], dat);
   endtask

   task automatic check_all(input string tag, input logic [3:0] flags, input logic [31:0] dat);
      for (int d = 0; d < NDUT; d++) check_dut(d, tag, flags, dat);
   endtask

   // 0 = ACK, 1 = RTY, 2 = ERR, for the request just counted
   function automatic int kind_of(input int d, input logic [31:0] a);
      if (a >= 32'h40) return 2;
      if (m_rp[d] != 0 && (m_cnt[d] % m_rp[d]) == 0) return 1;
      return 0;
   endfunction

   task automatic count_request(input logic [31:0] a, output int kind [NDUT]);
      for (int d = 0; d < NDUT; d++) begin
         m_cnt[d] = (m_cnt[d] + 1) % 65536;
         kind[d]  = kind_of(d, a);
      end
   endtask

   task automatic expect_term(input int d, input int kind, input logic w, input logic [31:0] a,
                              input logic [31:0] v, input logic [3:0] s, input string tag);
      logic [3:0]  f;
      logic [31:0] ed;
      f  = (kind == 0) ? 4'b1000 : (kind == 1) ? 4'b0100 : 4'b0010;
      ed = (kind == 0 && !w) ? m_mem[d][a[5:2]] : 32'd0;
      check_dut(d, tag, f, ed);
      if (kind == 0 && w)
         for (int b = 0; b < 4; b++)
            if (s[b]) m_mem[d][a[5:2]][8*b +: 8] = v[8*b +: 8];
   endtask

   // Entered and left #1 after a rising edge with the slave idle.
   task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] v,
                         input logic [3:0] s, input string tag);
      int kind [NDUT];
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = v; sel = s;
      @(posedge clk);
      count_request(a, kind);
      for (int k = 1; k < LAT; k++) begin
         @(posedge clk); #1;
         check_all({tag, ".wait"}, {3'b000, PIPE}, 32'd0);
      end
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) expect_term(d, kind[d], w, a, v, s, {tag, ".term"});
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      check_all({tag, ".after"}, 4'b0000, 32'd0);
   endtask

   task automatic abort_write(input logic [31:0] a, input logic [31:0] v);
      int kind [NDUT];
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = v; sel = 4'hF;
      @(posedge clk);
      count_request(a, kind);
      @(posedge clk); #1;
      check_all("abort.wait", {3'b000, PIPE}, 32'd0);
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      repeat (LAT) begin
         @(posedge clk); #1;
         check_all("abort.quiet", 4'b0000, 32'd0);
      end
   endtask

   task automatic release_reset();
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      for (int d = 0; d < NDUT; d++) m_cnt[d] = 0;
      repeat (LAT + 1) begin
         @(posedge clk); #1;
         check_all("rst.quiet", 4'b0000, 32'd0);
      end
   endtask

   task automatic reset_mid_wait(input logic [31:0] a, input logic [31:0] v);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_i = v; sel = 4'hF;
      @(posedge clk);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      check_all("rst_wait", 4'b0000, 32'd0);
      release_reset();
   endtask

   task automatic reset_in_pulse(input logic [31:0] a);
      int kind [NDUT];
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      @(posedge clk);
      count_request(a, kind);
      repeat (LAT) @(posedge clk);
      #1;
      for (int d = 0; d < NDUT; d++) expect_term(d, kind[d], 1'b0, a, 32'd0, 4'hF, "rst_pulse.term");
      #2;
      rst = 1'b0;
      #1;
      check_all("rst_pulse", 4'b0000, 32'd0);
      release_reset();
   endtask

   // STB_I held high across n back-to-back reads: acceptances LAT+1 apart.
   task automatic stream_reads(input int n, input logic [31:0] a);
      int kind [NDUT];
      int pos;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
      @(posedge clk);
      count_request(a, kind);
      for (int e = 1; e < n * (LAT + 1); e++) begin
         @(posedge clk); #1;
         pos = e % (LAT + 1);
         if (pos == LAT) begin
            for (int d = 0; d < NDUT; d++) expect_term(d, kind[d], 1'b0, a, 32'd0, 4'hF, "stream.term");
            if (e == n * (LAT + 1) - 1) begin
               cyc = 1'b0; stb = 1'b0;
            end
         end else begin
            if (pos == 0) count_request(a, kind);
            check_all("stream.busy", {3'b000, PIPE}, 32'd0);
         end
      end
      @(posedge clk); #1;
      check_all("stream.after", 4'b0000, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] init_val [16];
      logic [31:0] a;
      cyc = 1'b0; stb = 1'b0; we = 1'b0; dat_i = '0; adr = '0; sel = '0; cti = 3'd0;
      m_rp[0] = 0;
      m_rp[1] = RP1;
      for (int d = 0; d < NDUT; d++) m_cnt[d] = 0;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all("reset", 4'b0000, 32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;

      // Two passes so every word is written at least once in the retrying slave too.
      for (int i = 0; i < 16; i++) init_val[i] = $urandom();
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 16; i++) do_req(1'b1, 32'(i * 4), init_val[i], 4'hF, "init");

      do_req(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, "basic_wr");
      do_req(1'b0, 32'h8, 32'h0, 4'hF, "basic_rd");

      do_req(1'b1, 32'hC, 32'h11223344, 4'hF, "bsel_full");
      do_req(1'b1, 32'hC, 32'hAABBCCDD, 4'b0101, "bsel_part");
      do_req(1'b0, 32'hC, 32'h0, 4'hF, "bsel_rd");

      do_req(1'b1, 32'h40, 32'hCAFEF00D, 4'hF, "oor_wr");
      do_req(1'b0, 32'h0, 32'h0, 4'hF, "oor_alias_rd");

      abort_write(32'h14, 32'h55AA55AA);
      do_req(1'b0, 32'h14, 32'h0, 4'hF, "abort_rd");

      reset_mid_wait(32'h18, 32'h0BADF00D);
      // First six requests after reset: the retrying slave answers 3 and 6 with RTY.
      do_req(1'b0, 32'h18, 32'h0, 4'hF, "retry_rd1");
      for (int i = 0; i < 5; i++) do_req(1'b0, 32'(i * 4 + 4), 32'h0, 4'hF, "retry_rd");

      reset_in_pulse(32'h8);
      stream_reads(4, 32'hC);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 5) == 0) a = $urandom() | 32'h40;
         else a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         do_req(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)), "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
